// File: rtl/univ_shift_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register.
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Counter width able to represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_cell.sv
// One stage of the universal shift register: mode mux plus true and
// complement flops, both loaded from the same next-state value.
module shift_cell
  import univ_shift_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       left_src,
  input  logic       right_src,
  input  logic       par_bit,
  output logic       q,
  output logic       q_n
);

  logic d;

  // Select the next bit value; en=0 behaves exactly like hold.
  always_comb begin
    d = q;
    if (en) begin
      case (mode)
        MODE_HOLD:  d = q;
        MODE_LEFT:  d = left_src;
        MODE_RIGHT: d = right_src;
        default:    d = par_bit;
      endcase
    end
  end

  // Complement is its own flop so q_n has no inverter delay after the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q   <= RESET_BIT;
      q_n <= ~RESET_BIT;
    end else begin
      q   <= d;
      q_n <= ~d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: WIDTH shift_cell stages with left/right shift,
// parallel load and hold, plus a saturating shift counter with full flags.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             full_pulse
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

  logic [WIDTH-1:0] left_vec;
  logic [WIDTH-1:0] right_vec;
  logic             is_shift;
  logic             is_load;

  // Neighbour taps; the end cells see the serial inputs instead.
  assign left_vec  = {q[WIDTH-2:0], ser_in_l};
  assign right_vec = {ser_in_r, q[WIDTH-1:1]};

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

  assign is_shift = en && ((mode == MODE_LEFT) || (mode == MODE_RIGHT));
  assign is_load  = en && (mode == MODE_LOAD);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en),
      .mode      (mode),
      .left_src  (left_vec[i]),
      .right_src (right_vec[i]),
      .par_bit   (par_in[i]),
      .q         (q[i]),
      .q_n       (q_n[i])
    );
  end

  // Shift counter: counts every shift regardless of direction, saturates at
  // WIDTH, and a load clears it together with the full level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      full       <= 1'b0;
      full_pulse <= 1'b0;
    end else begin
      full_pulse <= 1'b0;
      if (is_load) begin
        cnt  <= '0;
        full <= 1'b0;
      end else if (is_shift && (cnt != CNT_MAX)) begin
        cnt        <= cnt + CW'(1);
        full       <= (cnt == CNT_PRE);
        full_pulse <= (cnt == CNT_PRE);
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: WIDTH=4, 2 and 33 instances share one
// stimulus stream; expectations are hand-derived per width.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic [1:0]  mode;
  logic        sl;
  logic        sr;
  logic [63:0] par;

  logic [3:0]  q4, qn4;
  logic        sol4, sor4, full4, fp4;
  logic [2:0]  cnt4;
  logic [1:0]  q2, qn2;
  logic        sol2, sor2, full2, fp2;
  logic [1:0]  cnt2;
  logic [32:0] q33, qn33;
  logic        sol33, sor33, full33, fp33;
  logic [5:0]  cnt33;

  int n_cmp = 0;
  int n_err = 0;
  int fpc4, fpc2, fpc33;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'hA)) dut4 (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
    .ser_in_l(sl), .ser_in_r(sr), .par_in(par[3:0]),
    .q(q4), .q_n(qn4), .ser_out_l(sol4), .ser_out_r(sor4),
    .cnt(cnt4), .full(full4), .full_pulse(fp4));

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b01)) dut2 (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
    .ser_in_l(sl), .ser_in_r(sr), .par_in(par[1:0]),
    .q(q2), .q_n(qn2), .ser_out_l(sol2), .ser_out_r(sor2),
    .cnt(cnt2), .full(full2), .full_pulse(fp2));

  univ_shift_reg #(.WIDTH(33), .RESET_VAL(33'h1_0000_0001)) dut33 (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
    .ser_in_l(sl), .ser_in_r(sr), .par_in(par[32:0]),
    .q(q33), .q_n(qn33), .ser_out_l(sol33), .ser_out_r(sor33),
    .cnt(cnt33), .full(full33), .full_pulse(fp33));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ck4(input string tag, input logic [3:0] eq, input int ecnt,
                     input logic efull, input logic efp);
    logic [3:0] en_q;
    en_q = ~eq;
    chk({tag, " w4 q"}, q4, eq);
    chk({tag, " w4 q_n"}, qn4, en_q);
    chk({tag, " w4 ser_out_l"}, sol4, eq[3]);
    chk({tag, " w4 ser_out_r"}, sor4, eq[0]);
    chk({tag, " w4 cnt"}, cnt4, ecnt);
    chk({tag, " w4 full"}, full4, efull);
    chk({tag, " w4 full_pulse"}, fp4, efp);
  endtask

  task automatic ck2(input string tag, input logic [1:0] eq, input int ecnt,
                     input logic efull, input logic efp);
    logic [1:0] en_q;
    en_q = ~eq;
    chk({tag, " w2 q"}, q2, eq);
    chk({tag, " w2 q_n"}, qn2, en_q);
    chk({tag, " w2 ser_out_l"}, sol2, eq[1]);
    chk({tag, " w2 ser_out_r"}, sor2, eq[0]);
    chk({tag, " w2 cnt"}, cnt2, ecnt);
    chk({tag, " w2 full"}, full2, efull);
    chk({tag, " w2 full_pulse"}, fp2, efp);
  endtask

  task automatic ck33(input string tag, input logic [32:0] eq, input int ecnt,
                      input logic efull, input logic efp);
    logic [32:0] en_q;
    en_q = ~eq;
    chk({tag, " w33 q"}, q33, eq);
    chk({tag, " w33 q_n"}, qn33, en_q);
    chk({tag, " w33 ser_out_l"}, sol33, eq[32]);
    chk({tag, " w33 ser_out_r"}, sor33, eq[0]);
    chk({tag, " w33 cnt"}, cnt33, ecnt);
    chk({tag, " w33 full"}, full33, efull);
    chk({tag, " w33 full_pulse"}, fp33, efp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0; reset_n = 1'b1; en = 1'b0; mode = MODE_HOLD;
    sl = 1'b0; sr = 1'b0; par = '0;

    // Reset asserted asynchronously, then released
    #2 reset_n = 1'b0;
    #1;
    ck4("rst", 4'hA, 0, 1'b0, 1'b0);
    ck2("rst", 2'b01, 0, 1'b0, 1'b0);
    ck33("rst", 33'h1_0000_0001, 0, 1'b0, 1'b0);
    step(); step();
    reset_n = 1'b1;
    step();
    ck4("rel", 4'hA, 0, 1'b0, 1'b0);

    // Load 3 then four left shifts 1,0,1,1
    en = 1'b1; mode = MODE_LOAD; par = 64'h3;
    step();
    ck4("ld3", 4'h3, 0, 1'b0, 1'b0);
    ck2("ld3", 2'b11, 0, 1'b0, 1'b0);
    ck33("ld3", 33'h3, 0, 1'b0, 1'b0);
    mode = MODE_LEFT; sl = 1'b1;
    step();
    ck4("L1", 4'h7, 1, 1'b0, 1'b0);
    ck2("L1", 2'b11, 1, 1'b0, 1'b0);
    ck33("L1", 33'h7, 1, 1'b0, 1'b0);
    sl = 1'b0;
    step();
    ck4("L2", 4'hE, 2, 1'b0, 1'b0);
    ck2("L2", 2'b10, 2, 1'b1, 1'b1);
    ck33("L2", 33'hE, 2, 1'b0, 1'b0);
    sl = 1'b1;
    step();
    ck4("L3", 4'hD, 3, 1'b0, 1'b0);
    ck2("L3", 2'b01, 2, 1'b1, 1'b0);
    ck33("L3", 33'h1D, 3, 1'b0, 1'b0);
    step();
    ck4("L4", 4'hB, 4, 1'b1, 1'b1);
    ck2("L4", 2'b11, 2, 1'b1, 1'b0);
    ck33("L4", 33'h3B, 4, 1'b0, 1'b0);

    // Load 0 while full, then four right shifts with ser_in_r=1
    mode = MODE_LOAD; par = 64'h0;
    step();
    ck4("ld0", 4'h0, 0, 1'b0, 1'b0);
    ck2("ld0", 2'b00, 0, 1'b0, 1'b0);
    ck33("ld0", 33'h0, 0, 1'b0, 1'b0);
    mode = MODE_RIGHT; sr = 1'b1;
    step();
    ck4("R1", 4'h8, 1, 1'b0, 1'b0);
    ck2("R1", 2'b10, 1, 1'b0, 1'b0);
    ck33("R1", 33'h1_0000_0000, 1, 1'b0, 1'b0);
    step();
    ck4("R2", 4'hC, 2, 1'b0, 1'b0);
    ck2("R2", 2'b11, 2, 1'b1, 1'b1);
    ck33("R2", 33'h1_8000_0000, 2, 1'b0, 1'b0);
    step();
    ck4("R3", 4'hE, 3, 1'b0, 1'b0);
    ck2("R3", 2'b11, 2, 1'b1, 1'b0);
    ck33("R3", 33'h1_C000_0000, 3, 1'b0, 1'b0);
    step();
    ck4("R4", 4'hF, 4, 1'b1, 1'b1);
    ck2("R4", 2'b11, 2, 1'b1, 1'b0);
    ck33("R4", 33'h1_E000_0000, 4, 1'b0, 1'b0);

    // Six mixed-direction shifts from cnt=0: saturation and single pulse
    mode = MODE_LOAD; par = 64'h0; sl = 1'b0; sr = 1'b0;
    step();
    fpc4 = 0; fpc2 = 0; fpc33 = 0;
    for (int k = 1; k <= 6; k++) begin
      mode = (k % 2 == 1) ? MODE_LEFT : MODE_RIGHT;
      step();
      fpc4 += int'(fp4); fpc2 += int'(fp2); fpc33 += int'(fp33);
      chk($sformatf("sat%0d w4 cnt", k), cnt4, (k < 4) ? k : 4);
      chk($sformatf("sat%0d w4 full", k), full4, (k >= 4) ? 1 : 0);
      chk($sformatf("sat%0d w2 cnt", k), cnt2, (k < 2) ? k : 2);
      chk($sformatf("sat%0d w33 cnt", k), cnt33, k);
    end
    chk("sat w4 pulse count", fpc4, 1);
    chk("sat w2 pulse count", fpc2, 1);
    chk("sat w33 pulse count", fpc33, 0);
    ck4("sat end", 4'h0, 4, 1'b1, 1'b0);
    mode = MODE_LOAD; par = 64'h5;
    step();
    ck4("ld5", 4'h5, 0, 1'b0, 1'b0);
    ck2("ld5", 2'b01, 0, 1'b0, 1'b0);
    ck33("ld5", 33'h5, 0, 1'b0, 1'b0);

    // Reach full, then en=0 with mode=left must freeze everything
    mode = MODE_LEFT; sl = 1'b1;
    step(); ck4("F1", 4'hB, 1, 1'b0, 1'b0);
    step(); ck4("F2", 4'h7, 2, 1'b0, 1'b0);
    step(); ck4("F3", 4'hF, 3, 1'b0, 1'b0);
    step(); ck4("F4", 4'hF, 4, 1'b1, 1'b1);
    ck33("F4", 33'h5F, 4, 1'b0, 1'b0);
    en = 1'b0; sl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      ck4($sformatf("frz%0d", k), 4'hF, 4, 1'b1, 1'b0);
    end
    ck33("frz", 33'h5F, 4, 1'b0, 1'b0);
    ck2("frz", 2'b11, 2, 1'b1, 1'b0);

    // Reset mid-period during shifting
    en = 1'b1; mode = MODE_LEFT; sl = 1'b0;
    step();
    ck4("pre-rst", 4'hE, 4, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    ck4("mid-rst", 4'hA, 0, 1'b0, 1'b0);
    ck2("mid-rst", 2'b01, 0, 1'b0, 1'b0);
    ck33("mid-rst", 33'h1_0000_0001, 0, 1'b0, 1'b0);
    #2 reset_n = 1'b1; en = 1'b0;
    step();
    ck4("post-rst", 4'hA, 0, 1'b0, 1'b0);
    en = 1'b1; sl = 1'b1;
    step();
    ck4("resume", 4'h5, 1, 1'b0, 1'b0);
    ck2("resume", 2'b11, 1, 1'b0, 1'b0);
    ck33("resume", 33'h3, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
